// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache line memory: line geometry and FSM encoding.
package dcache_pkg;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ACK  = 2'd2
    } mem_state_e;
endpackage

// File: rtl/dcache_line_memory_if.sv
// Cache-to-memory line bus: one request held until a single-cycle ack.
import dcache_pkg::*;

interface dcache_line_memory_if #(
    parameter int LINE_W = dcache_pkg::LINE_W
);
    logic              enable;
    logic              write;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wdata;
    logic              ack;
    logic [LINE_W-1:0] rdata;

    modport master (output enable, write, addr, wdata, input ack, rdata);
    modport slave  (input enable, write, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dcache_line_array.sv
// Line storage: synchronous write, combinational read, contents survive reset.
import dcache_pkg::*;

module dcache_line_array #(
    parameter int ADDR_LINES = 9,
    parameter int LINE_W     = dcache_pkg::LINE_W
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [ADDR_LINES-1:0] idx,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);
    logic [LINE_W-1:0] mem [2**ADDR_LINES];

    always_ff @(posedge clk_i) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/dcache_line_memory.sv
// Fixed-latency line memory behind the data cache: captures one request, acks it
// LATENCY cycles later and performs the read or write on the ack edge.
import dcache_pkg::*;

module dcache_line_memory #(
    parameter int LATENCY    = 10,
    parameter int ADDR_LINES = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dcache_line_memory_if.slave  bus
);
    localparam int               CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam bit               SKIP_WAIT = (LATENCY == 1);

    mem_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wr_q;
    logic [ADDR_LINES-1:0]   idx_q;
    logic [LINE_W-1:0]       wdata_q;
    logic [LINE_W-1:0]       rdata_q;

    logic [ADDR_LINES-1:0]   in_idx;
    logic [ADDR_LINES-1:0]   op_idx;
    logic                    op_write;
    logic [LINE_W-1:0]       op_wdata;
    logic [LINE_W-1:0]       arr_rdata;
    logic                    do_op;
    logic                    arr_we;
    logic                    accept;

    assign in_idx = bus.addr[ADDR_LINES+OFFSET_W-1:OFFSET_W];
    assign accept = (state_q == MEM_IDLE) && bus.enable;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= MEM_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (bus.enable) state_d = SKIP_WAIT ? MEM_ACK : MEM_WAIT;
            MEM_WAIT: if (cnt_q == CNT_W'(1)) state_d = MEM_ACK;
            MEM_ACK:  state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    // With LATENCY=1 the operation happens on the acceptance edge itself, so it
    // must come straight from the bus rather than from the capture registers.
    always_comb begin
        do_op    = (state_d == MEM_ACK) && (state_q != MEM_ACK);
        op_write = (state_q == MEM_IDLE) ? bus.write : wr_q;
        op_idx   = (state_q == MEM_IDLE) ? in_idx    : idx_q;
        op_wdata = (state_q == MEM_IDLE) ? bus.wdata : wdata_q;
        arr_we   = do_op && op_write && rst_i;
        bus.ack   = (state_q == MEM_ACK);
        bus.rdata = rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= bus.write;
                idx_q   <= in_idx;
                wdata_q <= bus.wdata;
                cnt_q   <= CNT_LOAD;
            end else if (state_q == MEM_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (do_op && !op_write) rdata_q <= arr_rdata;
        end
    end

    dcache_line_array #(
        .ADDR_LINES (ADDR_LINES),
        .LINE_W     (LINE_W)
    ) u_array (
        .clk_i (clk_i),
        .we    (arr_we),
        .idx   (op_idx),
        .wdata (op_wdata),
        .rdata (arr_rdata)
    );
endmodule

// File: tb/tb_dcache_line_memory.sv
// Bench for dcache_line_memory: directed scenarios plus random traffic against a
// line-indexed reference memory, on a LATENCY=10 and a LATENCY=1 instance.
import dcache_pkg::*;

module tb_dcache_line_memory;
    typedef logic [LINE_W-1:0] line_t;

    localparam int L0 = 10;
    localparam int L1 = 1;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    line_t m0_model [int];
    line_t m1_model [int];
    int    m0_keys [$];
    int    m1_keys [$];

    dcache_line_memory_if #(.LINE_W(LINE_W)) m0 ();
    dcache_line_memory_if #(.LINE_W(LINE_W)) m1 ();

    dcache_line_memory #(.LATENCY(L0), .ADDR_LINES(9)) u_dut0 (
        .clk_i (clk), .rst_i (rst_n), .bus (m0));
    dcache_line_memory #(.LATENCY(L1), .ADDR_LINES(9)) u_dut1 (
        .clk_i (clk), .rst_i (rst_n), .bus (m1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic line_t rnd_line();
        line_t v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic line_t rep8(input logic [7:0] b);
        line_t v;
        for (int i = 0; i < LINE_W / 8; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    function automatic line_t rep16(input logic [15:0] h);
        line_t v;
        for (int i = 0; i < LINE_W / 16; i++) v[i*16 +: 16] = h;
        return v;
    endfunction

    // Line index from the architectural rule: drop the 32-byte offset, wrap at 512.
    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 5) % 512);
    endfunction

    function automatic logic get_ack(input bit fast);
        return fast ? m1.ack : m0.ack;
    endfunction

    function automatic line_t get_rdata(input bit fast);
        return fast ? m1.rdata : m0.rdata;
    endfunction

    task automatic chk(input string tag, input line_t obs, input line_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit fast, input bit en, input bit wr,
                         input logic [31:0] a, input line_t d);
        if (fast) begin
            m1.enable = en; m1.write = wr; m1.addr = a; m1.wdata = d;
        end else begin
            m0.enable = en; m0.write = wr; m0.addr = a; m0.wdata = d;
        end
    endtask

    task automatic model_write(input bit fast, input logic [31:0] a, input line_t d);
        int k;
        k = line_of(a);
        if (fast) begin
            if (!m1_model.exists(k)) m1_keys.push_back(k);
            m1_model[k] = d;
        end else begin
            if (!m0_model.exists(k)) m0_keys.push_back(k);
            m0_model[k] = d;
        end
    endtask

    function automatic line_t model_read(input bit fast, input logic [31:0] a);
        return fast ? m1_model[line_of(a)] : m0_model[line_of(a)];
    endfunction

    // Called at a negedge with enable already held high across the acceptance
    // edge and then dropped; counts edges up to the ack and checks the pulse.
    task automatic wait_ack(input bit fast, input string tag, input bit is_rd,
                            input line_t exp);
        int n;
        n = 0;
        while (!get_ack(fast) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, line_t'(n), line_t'(fast ? L1 - 1 : L0 - 1));
        if (is_rd) chk({tag, "_data"}, get_rdata(fast), exp);
        @(negedge clk);
        chk({tag, "_pulse"}, line_t'(get_ack(fast)), line_t'(0));
    endtask

    task automatic run_op(input bit fast, input bit wr, input logic [31:0] a,
                          input line_t d, input string tag);
        line_t exp;
        exp = wr ? '0 : model_read(fast, a);
        @(negedge clk);
        drive(fast, 1'b1, wr, a, d);
        @(posedge clk);
        @(negedge clk);
        drive(fast, 1'b0, 1'b0, $urandom, rnd_line());
        wait_ack(fast, tag, !wr, exp);
        if (wr) model_write(fast, a, d);
    endtask

    initial begin
        line_t d, p1, p2, r0;
        logic [31:0] a;
        int k;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0",   line_t'(m0.ack), line_t'(0));
        chk("rst_rdata0", m0.rdata, '0);
        chk("rst_ack1",   line_t'(m1.ack), line_t'(0));
        chk("rst_rdata1", m1.rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Line 3 preload then read.
        run_op(1'b0, 1'b1, 32'h60, rep8(8'hA5), "pre_l3");
        run_op(1'b0, 1'b0, 32'h60, '0, "rd_l3");

        // Write then read the same line.
        run_op(1'b0, 1'b1, 32'h400, rep16(16'h1234), "wr_400");
        run_op(1'b0, 1'b0, 32'h400, '0, "rd_400");

        // Write-back then refill with enable held across the ack.
        r0 = rnd_line();
        run_op(1'b0, 1'b1, 32'h020, r0, "pre_020");
        d = rnd_line();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h7E0, d);
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!m0.ack && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wb_lat", line_t'(k), line_t'(L0 - 1));
        drive(1'b0, 1'b1, 1'b0, 32'h020, rnd_line());
        model_write(1'b0, 32'h7E0, d);
        @(negedge clk);
        chk("wb_idle_gap", line_t'(m0.ack), line_t'(0));
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, $urandom, rnd_line());
        wait_ack(1'b0, "refill", 1'b1, r0);
        run_op(1'b0, 1'b0, 32'h7E0, '0, "rd_7e0");

        // Inputs changing during WAIT must not affect the captured request.
        p1 = rnd_line();
        p2 = rnd_line();
        run_op(1'b0, 1'b1, 32'h100, p1, "pre_100");
        run_op(1'b0, 1'b1, 32'h300, p2, "pre_300");
        d = rnd_line();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h100, d);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h300, rnd_line());
        wait_ack(1'b0, "capt", 1'b0, '0);
        model_write(1'b0, 32'h100, d);
        run_op(1'b0, 1'b0, 32'h100, '0, "capt_rd_orig");
        run_op(1'b0, 1'b0, 32'h300, '0, "capt_rd_other");

        // Reset while a write is pending with five edges of latency left.
        p1 = rnd_line();
        run_op(1'b0, 1'b1, 32'h1A0, p1, "pre_1a0");
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h1A0, rnd_line());
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (m0.ack) k++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (m0.ack) k++;
        end
        chk("rst_mid_noack", line_t'(k), line_t'(0));
        run_op(1'b0, 1'b0, 32'h1A0, '0, "rst_mid_line");

        // Aliasing through the ignored upper address bits.
        run_op(1'b0, 1'b0, 32'h4060, '0, "alias_4060");

        // Single-cycle latency instance.
        d = rnd_line();
        run_op(1'b1, 1'b1, 32'h60, d, "f_wr_60");
        run_op(1'b1, 1'b0, 32'h4060, '0, "f_alias");

        // Random traffic on both instances.
        for (int i = 0; i < 24; i++) begin
            bit fast, wr;
            fast = (i >= 16);
            wr   = ($urandom_range(0, 2) == 0) || (fast ? m1_keys.size() == 0 : m0_keys.size() == 0);
            if (wr) k = $urandom_range(0, 511);
            else if (fast) k = m1_keys[$urandom_range(0, m1_keys.size() - 1)];
            else k = m0_keys[$urandom_range(0, m0_keys.size() - 1)];
            a = ($urandom & 32'hFFFF_C000) | (32'(k) << 5) | ($urandom & 32'h1F);
            run_op(fast, wr, a, rnd_line(), wr ? "rnd_wr" : "rnd_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
